sram16_ctrl: RTL and testbench
==============================

SRAM16_CTRL -- requirements
Module: sram16_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 SHALL have parameter RD_WAIT, default 2, output-enable pulse length in cycles; legal range 1..15.
REQ-003 SHALL have parameter WR_WAIT, default 2, write-enable pulse length in cycles; legal range 1..15.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  controller can accept a request this cycle.
REQ-008 in_rw  in  1  1 = write, 0 = read.
REQ-009 in_addr  in  ADDR_W  word address.
REQ-010 in_wdata  in  16  write data.
REQ-011 in_wmask  in  2  byte enables; bit1 = upper byte, bit0 = lower byte.
REQ-012 out_valid  out  1  one-cycle pulse; out_rdata valid.
REQ-013 out_rdata  out  16  read data.
REQ-014 sram_addr  out  ADDR_W  SRAM address.
REQ-015 sram_cs_n / sram_oe_n / sram_we_n / sram_ub_n / sram_lb_n  out  1 each  active-low SRAM strobes.
REQ-016 io_write  out  16  data to the bidirectional pad stage; the pad registers it one cycle before driving the pins.
REQ-017 io_write_enable  out  1  pad output enable; takes effect combinationally at the pad.
REQ-018 io_read  in  16  pin value as registered by the pad stage, one cycle behind the pins.

Function
REQ-019 SHALL implement states IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_PULSE, RD_SAMPLE.
REQ-020 in_ready SHALL equal 1 only in IDLE with reset low; a request is accepted when in_valid and in_ready are both 1.
REQ-021 On acceptance, in_rw, in_addr, in_wdata and in_wmask SHALL be latched; outputs SHALL use only latched values until the next return to IDLE.
REQ-022 Input changes SHALL be ignored while in_ready is 0.
REQ-023 In IDLE: all strobes 1, io_write_enable 0, sram_addr and io_write hold their last values.
REQ-024 Write path: IDLE -> WR_SETUP (1 cycle) -> WR_PULSE (WR_WAIT cycles) -> WR_HOLD (1 cycle) -> IDLE.
REQ-025 WR_SETUP: cs_n 0, we_n 1, io_write = data, io_write_enable 0; ub_n/lb_n = inverted mask.
REQ-026 WR_PULSE: we_n 0, io_write_enable 1; cs_n, ub_n/lb_n, addr and data as in WR_SETUP.
REQ-027 WR_HOLD: we_n 1, io_write_enable 1, cs_n 0; data and address held.
REQ-028 Read path: IDLE -> RD_PULSE (RD_WAIT cycles) -> RD_SAMPLE (1 cycle) -> IDLE.
REQ-029 RD_PULSE and RD_SAMPLE: cs_n 0, oe_n 0, ub_n 0, lb_n 0, io_write_enable 0.
REQ-030 In RD_SAMPLE, out_rdata SHALL load io_read; out_valid SHALL be 1 on the following cycle only.
REQ-031 Read latency: acceptance at cycle T -> out_valid at T+RD_WAIT+2; out_rdata SHALL hold until the next read completes.
REQ-032 Write mask 00 SHALL run the full write sequence with ub_n = lb_n = 1.
REQ-033 io_write_enable and oe_n = 0 SHALL never coincide.
REQ-034 A 4-bit down-counter SHALL time the pulse states and load RD_WAIT-1 or WR_WAIT-1 on entry.

Reset
REQ-035 While reset is 1: state IDLE; in_ready 0; out_valid 0; out_rdata 0; all strobes 1; io_write_enable 0; sram_addr 0; io_write 0.
REQ-036 Reset asserted in any state SHALL abort the operation; strobes and io_write_enable SHALL be inactive from the next edge.
REQ-037 An aborted read SHALL produce no out_valid.
REQ-038 in_ready SHALL rise on the first cycle after reset drops.

Verification
REQ-039 Write, WR_WAIT=2, addr 0x00010, data 0x1234, mask 11 -> we_n low exactly 2 cycles; io_write_enable high 3 cycles; pins = 0x1234 throughout we_n low.
REQ-040 Read addr 0x00010, RD_WAIT=2, SRAM model -> out_valid single pulse at T+4, out_rdata 0x1234.
REQ-041 Write 0xABCD, mask 01, to 0x00010, then read -> lb_n low and ub_n high during the write; read returns 0x12CD.
REQ-042 in_valid held high, alternating write/read for 8 requests -> in_ready high only in IDLE; no cycle with io_write_enable 1 and oe_n 0; every read returns last written data.
REQ-043 Reset pulsed during the 2nd WR_PULSE cycle, then during RD_PULSE -> next edge: we_n/oe_n/cs_n 1, io_write_enable 0; no out_valid; in_ready 1 one cycle after reset release.

Source files
------------

// File: rtl/sram16_ctrl_if.sv
// Request/response bus between a client and the sram16_ctrl asynchronous-SRAM controller.
// The master issues word reads/writes; the slave returns read data with a one-cycle pulse.
interface sram16_ctrl_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              in_valid;
  logic              in_ready;
  logic              in_rw;
  logic [ADDR_W-1:0] in_addr;
  logic [15:0]       in_wdata;
  logic [1:0]        in_wmask;
  logic              out_valid;
  logic [15:0]       out_rdata;

  modport master (
    output in_valid, in_rw, in_addr, in_wdata, in_wmask,
    input  in_ready, out_valid, out_rdata
  );

  modport slave (
    input  in_valid, in_rw, in_addr, in_wdata, in_wmask,
    output in_ready, out_valid, out_rdata
  );
endinterface

// File: rtl/sram16_ctrl.sv
// Single-port controller for a 16-bit asynchronous SRAM behind a registered bidirectional pad.
// All SRAM strobes and pad controls are registered; one request is in flight at a time.
module sram16_ctrl #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic              clock,
  input  logic              reset,
  sram16_ctrl_if.slave      bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic [15:0]       io_write,
  output logic              io_write_enable,
  input  logic [15:0]       io_read
);

  localparam logic [3:0] RdLoad = 4'(RD_WAIT - 1);
  localparam logic [3:0] WrLoad = 4'(WR_WAIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StRdPulse,
    StRdSample
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              cs_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q, io_we_q;
  logic              out_valid_q;
  logic [15:0]       rdata_q;

  // Combinational so that a request can never be accepted while reset is high.
  assign bus.in_ready  = (state_q == StIdle) && !reset;
  assign bus.out_valid = out_valid_q;
  assign bus.out_rdata = rdata_q;

  assign sram_addr       = addr_q;
  assign sram_cs_n       = cs_n_q;
  assign sram_oe_n       = oe_n_q;
  assign sram_we_n       = we_n_q;
  assign sram_ub_n       = ub_n_q;
  assign sram_lb_n       = lb_n_q;
  assign io_write        = wdata_q;
  assign io_write_enable = io_we_q;

  // Each transition programs the strobes for the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      io_we_q     <= 1'b0;
      out_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            addr_q <= bus.in_addr;
            cs_n_q <= 1'b0;
            if (bus.in_rw) begin
              state_q <= StWrSetup;
              wdata_q <= bus.in_wdata;
              ub_n_q  <= ~bus.in_wmask[1];
              lb_n_q  <= ~bus.in_wmask[0];
            end else begin
              state_q <= StRdPulse;
              cnt_q   <= RdLoad;
              oe_n_q  <= 1'b0;
              ub_n_q  <= 1'b0;
              lb_n_q  <= 1'b0;
            end
          end
        end
        StWrSetup: begin
          state_q <= StWrPulse;
          cnt_q   <= WrLoad;
          we_n_q  <= 1'b0;
          io_we_q <= 1'b1;
        end
        StWrPulse: begin
          if (cnt_q == 4'd0) begin
            state_q <= StWrHold;
            we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StWrHold: begin
          state_q <= StIdle;
          cs_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          io_we_q <= 1'b0;
        end
        StRdPulse: begin
          if (cnt_q == 4'd0) begin
            state_q <= StRdSample;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StRdSample: begin
          state_q     <= StIdle;
          rdata_q     <= io_read;
          out_valid_q <= 1'b1;
          cs_n_q      <= 1'b1;
          oe_n_q      <= 1'b1;
          ub_n_q      <= 1'b1;
          lb_n_q      <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram16_ctrl.sv
// Directed bench for sram16_ctrl with a registered pad stage and a behavioural async SRAM.
module tb_sram16_ctrl;
  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned RD_WAIT = 2;
  localparam int unsigned WR_WAIT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sram16_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  logic [ADDR_W-1:0] sram_addr;
  logic              sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [15:0]       io_write;
  logic              io_write_enable;
  logic [15:0]       io_read;

  sram16_ctrl #(
    .ADDR_W (ADDR_W),
    .RD_WAIT(RD_WAIT),
    .WR_WAIT(WR_WAIT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .sram_addr      (sram_addr),
    .sram_cs_n      (sram_cs_n),
    .sram_oe_n      (sram_oe_n),
    .sram_we_n      (sram_we_n),
    .sram_ub_n      (sram_ub_n),
    .sram_lb_n      (sram_lb_n),
    .io_write       (io_write),
    .io_write_enable(io_write_enable),
    .io_read        (io_read)
  );

  // Pad stage and SRAM model (only the low 256 words are populated).
  logic [15:0] pad_q;
  logic [15:0] pins;
  logic [15:0] mem [0:255];
  logic        hit;
  assign hit = (sram_addr[ADDR_W-1:8] == '0);

  always_comb begin
    pins = 16'h0000;
    if (io_write_enable) pins = pad_q;
    else if (!sram_cs_n && !sram_oe_n && sram_we_n && hit) pins = mem[sram_addr[7:0]];
  end

  always @(posedge clock) begin
    pad_q   <= io_write;
    io_read <= pins;
    if (!sram_cs_n && !sram_we_n && hit) begin
      if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= pins[7:0];
      if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= pins[15:8];
    end
  end

  int overlap_cnt = 0;
  always @(negedge clock) if (io_write_enable && !sram_oe_n) overlap_cnt++;

  int checks = 0;
  int errors = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic issue(input logic rw, input logic [ADDR_W-1:0] a, input logic [15:0] d,
                       input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_rw    = rw;
    bus.in_addr  = a;
    bus.in_wdata = d;
    bus.in_wmask = m;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_accept: got no in_ready want in_ready within 50 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_rdata !== 16'h0) begin errors++;
      $display("FAIL reset_out: got %b/%h want 0/0000", bus.out_valid, bus.out_rdata); end
    checks++;
    if ({sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin errors++;
      $display("FAIL reset_strobes: got %b want 11111",
               {sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}); end
    checks++; if (io_write_enable !== 1'b0) begin errors++;
      $display("FAIL reset_io_we: got %b want 0", io_write_enable); end
    checks++; if (sram_addr !== '0 || io_write !== 16'h0) begin errors++;
      $display("FAIL reset_addr_data: got %h/%h want 0/0", sram_addr, io_write); end
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++; if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_write();
    int we_lo = 0, iowe = 0, cs_lo = 0, bad = 0;
    issue(1'b1, 18'h00010, 16'h1234, 2'b11);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (!sram_we_n) begin
        we_lo++;
        if (pins !== 16'h1234 || sram_addr !== 18'h00010 || sram_ub_n !== 1'b0 ||
            sram_lb_n !== 1'b0) bad++;
      end
      if (io_write_enable) iowe++;
      if (!sram_cs_n) cs_lo++;
    end
    checks++; if (we_lo !== WR_WAIT) begin errors++;
      $display("FAIL write_we_len: got %0d want %0d", we_lo, WR_WAIT); end
    checks++; if (iowe !== 3) begin errors++;
      $display("FAIL write_io_we_len: got %0d want 3", iowe); end
    checks++; if (cs_lo !== 4) begin errors++;
      $display("FAIL write_cs_len: got %0d want 4", cs_lo); end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL write_pins: got %0d bad cycles want 0", bad); end
    checks++; if (mem[8'h10] !== 16'h1234) begin errors++;
      $display("FAIL write_mem: got %h want 1234", mem[8'h10]); end
  endtask

  task automatic test_read(input logic [ADDR_W-1:0] a, input logic [15:0] exp);
    int pulses = 0, at = 0, oe_lo = 0;
    issue(1'b0, a, 16'hFFFF, 2'b11);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (bus.out_valid) begin pulses++; at = k; end
      if (!sram_oe_n) oe_lo++;
    end
    checks++; if (pulses !== 1 || at !== RD_WAIT + 2) begin errors++;
      $display("FAIL read_valid: got %0d pulses at +%0d want 1 at +%0d", pulses, at, RD_WAIT + 2);
    end
    checks++; if (bus.out_rdata !== exp) begin errors++;
      $display("FAIL read_data: got %h want %h", bus.out_rdata, exp); end
    checks++; if (oe_lo !== RD_WAIT + 1) begin errors++;
      $display("FAIL read_oe_len: got %0d want %0d", oe_lo, RD_WAIT + 1); end
  endtask

  task automatic test_write_mask();
    int we_lo = 0, bad = 0;
    checks++; if (bus.out_rdata !== 16'h1234) begin errors++;
      $display("FAIL rdata_hold: got %h want 1234", bus.out_rdata); end
    issue(1'b1, 18'h00010, 16'hABCD, 2'b01);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (!sram_we_n) begin
        we_lo++;
        if (sram_lb_n !== 1'b0 || sram_ub_n !== 1'b1) bad++;
      end
    end
    checks++; if (we_lo !== WR_WAIT || bad !== 0) begin errors++;
      $display("FAIL mask01_strobes: got %0d we cycles %0d bad want %0d/0", we_lo, bad, WR_WAIT);
    end
    test_read(18'h00010, 16'h12CD);
  endtask

  task automatic test_mask_zero();
    int we_lo = 0, iowe = 0, byte_lo = 0;
    issue(1'b1, 18'h00010, 16'hFFFF, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (!sram_we_n) we_lo++;
      if (io_write_enable) iowe++;
      if (!sram_ub_n || !sram_lb_n) byte_lo++;
    end
    checks++; if (we_lo !== WR_WAIT || iowe !== 3) begin errors++;
      $display("FAIL mask00_seq: got we %0d io_we %0d want %0d/3", we_lo, iowe, WR_WAIT); end
    checks++; if (byte_lo !== 0) begin errors++;
      $display("FAIL mask00_bytes: got %0d cycles with ub/lb low want 0", byte_lo); end
    test_read(18'h00010, 16'h12CD);
  endtask

  task automatic test_back_to_back();
    logic [15:0] last_wr;
    logic [15:0] expq[$];
    logic [15:0] e;
    int acc = 0, reads = 0, rd_bad = 0, rdy_bad = 0, cyc = 0;
    bit rdy;
    last_wr      = 16'h0;
    bus.in_rw    = 1'b1;
    bus.in_addr  = 18'h00020;
    bus.in_wdata = 16'h5A00;
    bus.in_wmask = 2'b11;
    bus.in_valid = 1'b1;
    while ((acc < 8 || reads < 4) && cyc < 300) begin
      @(negedge clock);
      cyc++;
      // cs_n is high exactly in the idle state
      if (bus.in_ready !== sram_cs_n) rdy_bad++;
      if (bus.out_valid) begin
        reads++;
        if (expq.size() == 0) rd_bad++;
        else begin
          e = expq.pop_front();
          if (bus.out_rdata !== e) rd_bad++;
        end
      end
      rdy = bus.in_ready && bus.in_valid;
      @(posedge clock);
      #1;
      if (rdy) begin
        if (bus.in_rw) last_wr = bus.in_wdata;
        else expq.push_back(last_wr);
        acc++;
        if (acc < 8) begin
          bus.in_rw    = (acc % 2 == 0);
          bus.in_addr  = 18'h00020 + 18'(acc / 2);
          bus.in_wdata = (acc % 2 == 0) ? 16'h5A00 + 16'(acc * 16'h0111) : 16'hDEAD;
          bus.in_wmask = (acc % 2 == 0) ? 2'b11 : 2'b00;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (acc !== 8 || reads !== 4) begin errors++;
      $display("FAIL b2b_count: got %0d accepted %0d reads want 8/4", acc, reads); end
    checks++; if (rd_bad !== 0) begin errors++;
      $display("FAIL b2b_rdata: got %0d bad reads want 0", rd_bad); end
    checks++; if (rdy_bad !== 0) begin errors++;
      $display("FAIL b2b_ready: got %0d cycles ready outside idle want 0", rdy_bad); end
    checks++; if (overlap_cnt !== 0) begin errors++;
      $display("FAIL oe_we_overlap: got %0d cycles want 0", overlap_cnt); end
  endtask

  task automatic test_reset_abort();
    int vcnt = 0;
    issue(1'b1, 18'h00030, 16'h7777, 2'b11);
    @(negedge clock);
    @(negedge clock);
    checks++; if (sram_we_n !== 1'b0) begin errors++;
      $display("FAIL abort_wr_pulse: got we_n %b want 0", sram_we_n); end
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checks++; if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL abort_ready_in_reset: got %b want 0", bus.in_ready); end
    @(posedge clock);
    #1;
    checks++;
    if ({sram_cs_n, sram_we_n, sram_oe_n, io_write_enable} !== 4'b1110) begin errors++;
      $display("FAIL abort_wr_strobes: got %b want 1110",
               {sram_cs_n, sram_we_n, sram_oe_n, io_write_enable}); end
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL abort_wr_ready: got %b want 1", bus.in_ready); end

    issue(1'b0, 18'h00010, 16'h0000, 2'b11);
    @(negedge clock);
    if (bus.out_valid) vcnt++;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if ({sram_cs_n, sram_we_n, sram_oe_n, io_write_enable} !== 4'b1110) begin errors++;
      $display("FAIL abort_rd_strobes: got %b want 1110",
               {sram_cs_n, sram_we_n, sram_oe_n, io_write_enable}); end
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (bus.out_valid) vcnt++;
    end
    checks++; if (vcnt !== 0 || bus.out_rdata !== 16'h0) begin errors++;
      $display("FAIL abort_rd_valid: got %0d pulses rdata %h want 0/0000", vcnt, bus.out_rdata);
    end
    checks++; if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL abort_rd_ready: got %b want 1", bus.in_ready); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_rw    = 1'b0;
    bus.in_addr  = '0;
    bus.in_wdata = '0;
    bus.in_wmask = '0;
    test_reset();
    test_write();
    test_read(18'h00010, 16'h1234);
    test_write_mask();
    test_mask_zero();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
